// File: rtl/lane_scroll_scheduler.sv
// Per-lane horizontal scroll offsets for the tile playfield.
// One lane is advanced per cycle during a sweep triggered by the frame tick.
module lane_scroll_scheduler #(
   parameter int unsigned NUM_LANES = 15,
   parameter int unsigned SCREEN_W  = 640,
   parameter int unsigned OFFSET_W  = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_tick_i,
   input  logic                enable_i,
   input  logic [1:0]          level_i,
   input  logic                sync_clear_i,
   input  logic [3:0]          rd_row_i,
   output logic [OFFSET_W-1:0] rd_offset_o,
   output logic                busy_o,
   output logic                update_done_o,
   output logic                overrun_o
);

   localparam logic [3:0]        LastLane = 4'(NUM_LANES - 1);
   localparam logic [3:0]        NumLanes = 4'(NUM_LANES);
   localparam logic [OFFSET_W:0] ScreenW  = (OFFSET_W + 1)'(SCREEN_W);

   typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

   state_e              state_q, state_d;
   logic [3:0]          idx_q, idx_d;
   logic                overrun_q, overrun_d;
   logic [OFFSET_W-1:0] rd_offset_q, rd_offset_d;
   logic [OFFSET_W-1:0] offset_q [NUM_LANES];
   logic [OFFSET_W-1:0] offset_d [NUM_LANES];

   // Rows 0, 7 and 14 are static; the rest move by (row mod 3) + 1 + level.
   function automatic logic [2:0] lane_step(input logic [3:0] row, input logic [1:0] lvl);
      logic [3:0] m;
      m = row % 4'd3;
      if (row == 4'd0 || row == 4'd7 || row == 4'd14) begin
         return 3'd0;
      end
      return 3'(m) + 3'd1 + {1'b0, lvl};
   endfunction

   function automatic logic [OFFSET_W-1:0] wrap_step(input logic [OFFSET_W-1:0] off,
                                                     input logic [2:0]          step,
                                                     input logic                right);
      logic [OFFSET_W:0] off_x;
      logic [OFFSET_W:0] step_x;
      logic [OFFSET_W:0] s;
      off_x  = {1'b0, off};
      step_x = (OFFSET_W + 1)'(step);
      if (right) begin
         s = off_x + step_x;
         if (s >= ScreenW) begin
            s = s - ScreenW;
         end
      end else if (off_x < step_x) begin
         s = off_x + ScreenW - step_x;
      end else begin
         s = off_x - step_x;
      end
      return s[OFFSET_W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      offset_d  = offset_q;
      // Restart wins over everything, including a coincident tick.
      if (sync_clear_i) begin
         state_d = StIdle;
         idx_d   = '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            offset_d[i] = '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (frame_tick_i && enable_i) begin
                  state_d = StUpdate;
                  idx_d   = '0;
               end
            end
            StUpdate: begin
               offset_d[idx_q] = wrap_step(offset_q[idx_q], lane_step(idx_q, level_i), idx_q[0]);
               if (idx_q == LastLane) begin
                  state_d = StDone;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
               if (frame_tick_i) begin
                  overrun_d = 1'b1;
               end
            end
            StDone: begin
               state_d = StIdle;
               if (frame_tick_i) begin
                  overrun_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Reads see the pre-write value when the same lane is written this cycle.
   always_comb begin
      rd_offset_d = '0;
      if (rd_row_i < NumLanes) begin
         rd_offset_d = offset_q[rd_row_i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         overrun_q   <= 1'b0;
         rd_offset_q <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            offset_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         overrun_q   <= overrun_d;
         rd_offset_q <= rd_offset_d;
         for (int i = 0; i < NUM_LANES; i++) begin
            offset_q[i] <= offset_d[i];
         end
      end
   end

   assign rd_offset_o   = rd_offset_q;
   assign busy_o        = (state_q == StUpdate);
   assign update_done_o = (state_q == StDone);
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_lane_scroll_scheduler.sv
// Directed bench for lane_scroll_scheduler: vector table of sweep results
// plus hand-written sequences for timing, overrun, clear and enable gating.
module tb_lane_scroll_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       enable = 1'b0;
   logic       sync_clear = 1'b0;
   logic [1:0] level = 2'd0;
   logic [3:0] rd_row = 4'd0;
   logic [9:0] rd_offset;
   logic       busy;
   logic       update_done;
   logic       overrun;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lane_scroll_scheduler #(
      .NUM_LANES(15),
      .SCREEN_W (640),
      .OFFSET_W (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick_i (frame_tick),
      .enable_i     (enable),
      .level_i      (level),
      .sync_clear_i (sync_clear),
      .rd_row_i     (rd_row),
      .rd_offset_o  (rd_offset),
      .busy_o       (busy),
      .update_done_o(update_done),
      .overrun_o    (overrun)
   );

   typedef struct {
      logic [1:0] lvl;
      int         ticks;
      logic [3:0] row;
      logic [9:0] exp;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      enable     = 1'b0;
      sync_clear = 1'b0;
      level      = 2'd0;
      rd_row     = 4'd0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic sweep(input logic [1:0] lvl);
      bit seen;
      seen       = 1'b0;
      level      = lvl;
      enable     = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (update_done) seen = 1'b1;
         else step();
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL sweep_timeout: update_done absent, required within 40 cycles");
      end
      step();
   endtask

   task automatic read_row(input logic [3:0] r, output logic [9:0] v);
      rd_row = r;
      step();
      v = rd_offset;
   endtask

   initial begin
      logic [9:0] v;
      int busy_cnt, done_edge, done_cnt, busy_seen;
      logic [9:0] pre, post;

      vecs[0]  = '{2'd0, 1,   4'd0,  10'd0};
      vecs[1]  = '{2'd0, 1,   4'd1,  10'd2};
      vecs[2]  = '{2'd0, 1,   4'd2,  10'd637};
      vecs[3]  = '{2'd0, 1,   4'd3,  10'd1};
      vecs[4]  = '{2'd0, 1,   4'd7,  10'd0};
      vecs[5]  = '{2'd0, 1,   4'd13, 10'd2};
      vecs[6]  = '{2'd0, 1,   4'd14, 10'd0};
      vecs[7]  = '{2'd0, 1,   4'd15, 10'd0};
      vecs[8]  = '{2'd3, 1,   4'd1,  10'd5};
      vecs[9]  = '{2'd3, 1,   4'd2,  10'd634};
      vecs[10] = '{2'd3, 1,   4'd8,  10'd634};
      vecs[11] = '{2'd3, 1,   4'd13, 10'd5};
      vecs[12] = '{2'd0, 320, 4'd1,  10'd0};
      vecs[13] = '{2'd0, 213, 4'd2,  10'd1};
      vecs[14] = '{2'd1, 2,   4'd4,  10'd634};
      vecs[15] = '{2'd2, 1,   4'd5,  10'd5};
      vecs[16] = '{2'd0, 3,   4'd6,  10'd637};

      // Reset state, sweep timing and same-cycle read/write ordering.
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", update_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_rd_offset", rd_offset, 0);
      rd_row     = 4'd1;
      level      = 2'd0;
      enable     = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      busy_cnt  = 0;
      done_edge = 0;
      pre       = '1;
      post      = '1;
      for (int k = 0; k < 25; k++) begin
         if (busy) busy_cnt++;
         if (update_done && done_edge == 0) done_edge = k + 1;
         if (k == 2) pre = rd_offset;
         if (k == 3) post = rd_offset;
         step();
      end
      check("busy_cycles", busy_cnt, 15);
      check("done_edge", done_edge, 16);
      check("same_cycle_read_old", pre, 0);
      check("next_read_new", post, 2);

      // Table-driven sweep results.
      for (int i = 0; i < NV; i++) begin
         if (i == 0 || vecs[i].lvl != vecs[i-1].lvl || vecs[i].ticks != vecs[i-1].ticks) begin
            do_reset();
            for (int t = 0; t < vecs[i].ticks; t++) sweep(vecs[i].lvl);
         end
         read_row(vecs[i].row, v);
         check($sformatf("vec%0d_row%0d", i, vecs[i].row), v, vecs[i].exp);
      end

      // Tick re-pulsed mid-sweep.
      do_reset();
      enable     = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (4) step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (update_done) done_cnt++;
         step();
      end
      check("overrun_done_count", done_cnt, 1);
      check("overrun_flag", overrun, 1);
      read_row(4'd1, v);
      check("overrun_row1", v, 2);
      read_row(4'd2, v);
      check("overrun_row2", v, 637);

      // sync_clear with coincident tick on the 8th update cycle.
      do_reset();
      sweep(2'd0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (7) step();
      check("clr_busy_before", busy, 1);
      sync_clear = 1'b1;
      frame_tick = 1'b1;
      step();
      sync_clear = 1'b0;
      frame_tick = 1'b0;
      check("clr_busy_after", busy, 0);
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (update_done) done_cnt++;
         step();
      end
      check("clr_no_done", done_cnt, 0);
      check("clr_overrun", overrun, 0);
      read_row(4'd1, v);
      check("clr_row1", v, 0);
      read_row(4'd2, v);
      check("clr_row2", v, 0);
      read_row(4'd13, v);
      check("clr_row13", v, 0);

      // enable low gates ticks; read latency follows rd_row changes.
      do_reset();
      sweep(2'd0);
      enable    = 1'b0;
      busy_seen = 0;
      for (int t = 0; t < 3; t++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         if (busy) busy_seen++;
         for (int k = 0; k < 3; k++) begin
            step();
            if (busy) busy_seen++;
         end
      end
      check("dis_busy_seen", busy_seen, 0);
      read_row(4'd1, v);
      check("dis_row1", v, 2);
      rd_row = 4'd2;
      #1;
      check("latency_hold", rd_offset, 2);
      step();
      check("latency_new", rd_offset, 637);
      read_row(4'd15, v);
      check("row15_zero", v, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
